// File: rtl/div_sequencer_pkg.sv
// Shared ISA definitions for the Execute-stage divide sequencer: ALU opcodes and FSM states.
package div_sequencer_pkg;

    localparam int unsigned ALUCONTROL_WIDTH = 6;

    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_UDIV = 6'b101110;
    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SDIV = 6'b101111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring divide iteration: shift in the next dividend bit, trial-subtract divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, q_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        q_o     = {q_i[WIDTH-2:0], 1'b0};
        rem_o   = shifted[WIDTH-1:0];
        // Top bit of the widened difference is the borrow: clear means shifted >= divisor.
        if (!diff[WIDTH]) begin
            rem_o  = diff[WIDTH-1:0];
            q_o[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle UDIV/SDIV sequencer beside the ALU; stalls F/D/E until quotient/remainder are ready.
module div_sequencer #(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned ALUCONTROL_WIDTH = div_sequencer_pkg::ALUCONTROL_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        StartE,
    input  logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
    input  logic [WIDTH-1:0]            SrcAE,
    input  logic [WIDTH-1:0]            SrcBE,
    input  logic                        FlushE,
    output logic                        StallDivE,
    output logic                        DivDoneE,
    output logic [WIDTH-1:0]            QuotientE,
    output logic [WIDTH-1:0]            RemainderE,
    output logic                        DivByZeroE
);

    import div_sequencer_pkg::*;

    localparam int unsigned CntW = $clog2(WIDTH);

    div_state_e       state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] q_q, rem_q, dvsr_q;
    logic [WIDTH-1:0] quot_out_q, rem_out_q;
    logic             op_signed_q, sgn_q_q, sgn_r_q, dbz_q;

    logic             is_udiv, is_sdiv, go, div_zero;
    logic [WIDTH-1:0] a_mag, b_mag, step_rem, step_q;

    always_comb begin
        is_udiv  = (ALUControlE == ALUCONTROL_WIDTH'(ALU_UDIV));
        is_sdiv  = (ALUControlE == ALUCONTROL_WIDTH'(ALU_SDIV));
        go       = StartE && (is_udiv || is_sdiv) && !FlushE;
        div_zero = (SrcBE == '0);
        a_mag    = (is_sdiv && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
        b_mag    = (is_sdiv && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .q_i      (q_q),
        .divisor_i(dvsr_q),
        .rem_o    (step_rem),
        .q_o      (step_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            quot_out_q  <= '0;
            rem_out_q   <= '0;
            op_signed_q <= 1'b0;
            sgn_q_q     <= 1'b0;
            sgn_r_q     <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        op_signed_q <= is_sdiv;
                        sgn_q_q     <= is_sdiv && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                        sgn_r_q     <= is_sdiv && SrcAE[WIDTH-1];
                        q_q         <= a_mag;
                        dvsr_q      <= b_mag;
                        rem_q       <= '0;
                        cnt_q       <= CntW'(WIDTH - 1);
                        // A zero divisor skips the iteration and reports the dividend unchanged.
                        if (div_zero) begin
                            quot_out_q <= '0;
                            rem_out_q  <= SrcAE;
                            dbz_q      <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            dbz_q   <= 1'b0;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (FlushE) begin
                        state_q <= StIdle;
                    end else begin
                        rem_q <= step_rem;
                        q_q   <= step_q;
                        if (cnt_q == '0) begin
                            state_q <= StFix;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                StFix: begin
                    if (FlushE) begin
                        state_q <= StIdle;
                    end else begin
                        quot_out_q <= (op_signed_q && sgn_q_q) ? -q_q : q_q;
                        rem_out_q  <= (op_signed_q && sgn_r_q) ? -rem_q : rem_q;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        StallDivE  = ((state_q == StIdle) && go && !div_zero) || (state_q == StCalc) ||
                     (state_q == StFix);
        DivDoneE   = (state_q == StDone);
        QuotientE  = quot_out_q;
        RemainderE = rem_out_q;
        DivByZeroE = dbz_q;
    end

endmodule
